// File: rtl/mode_pkg.sv
// Shared definitions for the mode-select path: scale codes, blinker states and
// the scale-code to pulse-count mapping.
package mode_pkg;

  localparam logic [2:0] SCL_SLOW   = 3'b000;
  localparam logic [2:0] SCL_MED_LO = 3'b011;
  localparam logic [2:0] SCL_MED    = 3'b101;
  localparam logic [2:0] SCL_FAST   = 3'b111;

  typedef enum logic [2:0] {
    LATCH,
    ON,
    OFF,
    GAP,
    RESTART,
    ERR
  } blink_state_t;

  // Zero marks a code the button front-end should never produce.
  function automatic logic [2:0] scale_to_pulses(input logic [2:0] code);
    case (code)
      SCL_SLOW:   return 3'd1;
      SCL_MED_LO: return 3'd2;
      SCL_MED:    return 3'd3;
      SCL_FAST:   return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Free-running cycle counter with synchronous clear; flags the last cycle of a
// window of tc cycles. It never wraps on its own, the owner clears it.
module cyc_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] tc,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign expire = (count == tc - ONE);

endmodule

// File: rtl/mode_led_blinker.sv
// Turns the current mode scale code into an LED pattern: N pulses, a long gap,
// repeat. Unknown codes light the LED steadily until a valid code returns.
module mode_led_blinker
  import mode_pkg::*;
#(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int GAP_CYC     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] scale,
  output logic       led,
  output logic       burst_done
);

  localparam int TMAX = (HALF_PERIOD > GAP_CYC) ? HALF_PERIOD : GAP_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] TC_HALF = TW'(HALF_PERIOD);
  localparam logic [TW-1:0] TC_GAP  = TW'(GAP_CYC);

  blink_state_t state;
  blink_state_t next_state;

  logic [2:0]    cur_scale;
  logic [2:0]    target;
  logic [2:0]    pulse_cnt;
  logic          expire;
  logic          timer_clear;
  logic [TW-1:0] timer_tc;
  logic          scale_valid;
  logic          scale_changed;
  logic          led_d;
  logic          done_d;

  assign scale_valid   = (scale_to_pulses(scale) != 3'd0);
  assign scale_changed = (scale != cur_scale);

  // Every state change restarts the window; ERR holds the timer idle.
  assign timer_clear = (next_state != state) || (state == ERR);
  assign timer_tc    = (state == GAP) ? TC_GAP : TC_HALF;

  cyc_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .tc     (timer_tc),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LATCH;
    end else begin
      state <= next_state;
    end
  end

  // A scale change outranks a timer expiry in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      LATCH: begin
        next_state = scale_valid ? ON : ERR;
      end
      ON: begin
        if (scale_changed) begin
          next_state = RESTART;
        end else if (expire) begin
          next_state = OFF;
        end
      end
      OFF: begin
        if (scale_changed) begin
          next_state = RESTART;
        end else if (expire) begin
          next_state = (pulse_cnt == target) ? GAP : ON;
        end
      end
      GAP: begin
        if (scale_changed) begin
          next_state = RESTART;
        end else if (expire) begin
          next_state = LATCH;
        end
      end
      RESTART: begin
        if (expire) begin
          next_state = LATCH;
        end
      end
      ERR: begin
        if (scale_valid) begin
          next_state = RESTART;
        end
      end
      default: begin
        next_state = LATCH;
      end
    endcase
  end

  // Outputs are decoded from next_state so the flops line up with the state register.
  always_comb begin
    led_d  = (next_state == ON) || (next_state == ERR);
    done_d = (state == GAP) && (next_state == LATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      led        <= led_d;
      burst_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_scale <= SCL_MED;
      target    <= 3'd0;
      pulse_cnt <= 3'd0;
    end else if (state == LATCH) begin
      cur_scale <= scale;
      target    <= scale_to_pulses(scale);
      pulse_cnt <= 3'd0;
    end else if ((state == ON) && (next_state == OFF)) begin
      pulse_cnt <= pulse_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mode_led_blinker.sv
// Bench for mode_led_blinker with short timing; a queue-based model plans each
// burst as a list of expected cycles and is compared on every falling edge.
module tb_mode_led_blinker;

  localparam int HP  = 4;
  localparam int GAP = 10;

  localparam logic [1:0] K_BURST   = 2'd0;
  localparam logic [1:0] K_RESTART = 2'd1;
  localparam logic [1:0] K_LATCH   = 2'd2;
  localparam logic [1:0] K_ERR     = 2'd3;

  typedef struct packed {
    logic       led;
    logic       done;
    logic [1:0] kind;
  } ent_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] scale = 3'b101;
  logic       led;
  logic       burst_done;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t       q[$];
  logic [1:0] m_kind;
  logic [2:0] m_scale;
  logic       exp_led;
  logic       exp_done;

  mode_led_blinker #(
    .HALF_PERIOD (HP),
    .GAP_CYC     (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scale      (scale),
    .led        (led),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  function automatic int pulses_for(input logic [2:0] s);
    case (s)
      3'b000:  return 1;
      3'b011:  return 2;
      3'b101:  return 3;
      3'b111:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic ent_t mk(input logic l, input logic d, input logic [1:0] k);
    ent_t e;
    e.led  = l;
    e.done = d;
    e.kind = k;
    return e;
  endfunction

  task automatic plan_restart();
    q.delete();
    for (int i = 0; i < HP; i++) q.push_back(mk(1'b0, 1'b0, K_RESTART));
    q.push_back(mk(1'b0, 1'b0, K_LATCH));
  endtask

  task automatic plan_burst(input int n);
    q.delete();
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < HP; i++) q.push_back(mk(1'b1, 1'b0, K_BURST));
      for (int i = 0; i < HP; i++) q.push_back(mk(1'b0, 1'b0, K_BURST));
    end
    for (int i = 0; i < GAP; i++) q.push_back(mk(1'b0, 1'b0, K_BURST));
    q.push_back(mk(1'b0, 1'b1, K_LATCH));
  endtask

  // Reference model: each step decides the cycle that the rising edge begins.
  initial begin
    ent_t e;
    q.delete();
    m_kind   = K_LATCH;
    m_scale  = 3'b101;
    exp_led  = 1'b0;
    exp_done = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_kind   = K_LATCH;
        m_scale  = 3'b101;
        exp_led  = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (m_kind == K_LATCH) begin
          m_scale = scale;
          if (pulses_for(scale) == 0) begin
            q.delete();
            q.push_back(mk(1'b1, 1'b0, K_ERR));
          end else begin
            plan_burst(pulses_for(scale));
          end
        end else if (m_kind == K_BURST && scale != m_scale) begin
          plan_restart();
        end else if (m_kind == K_ERR) begin
          if (pulses_for(scale) != 0) begin
            plan_restart();
          end else begin
            q.delete();
            q.push_back(mk(1'b1, 1'b0, K_ERR));
          end
        end
        e = q.pop_front();
        m_kind   = e.kind;
        exp_led  = e.led;
        exp_done = e.done;
      end
    end
  end

  task automatic do_reset(input logic [2:0] s);
    rst_n = 1'b0;
    scale = s;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    scale = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== 1'b0 || burst_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset k=%0d led=%b done=%b required 0/0", k, led, burst_done);
      end
    end
  endtask

  task automatic test_med_101();
    do_reset(3'b101);
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL med_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (k == 35 || k == 70) begin
        n_cmp++;
        if (burst_done !== 1'b1) begin
          n_fail++;
          $display("FAIL med_done_at_%0d got=%b required 1", k, burst_done);
        end
      end
    end
  endtask

  task automatic test_slow_period();
    int first;
    int last;
    int pulses;
    int bad_gap;
    first = -1;
    last = -1;
    pulses = 0;
    bad_gap = 0;
    do_reset(3'b000);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL slow_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (burst_done === 1'b1) begin
        if (first < 0) first = k;
        if (last >= 0 && k - last != 19) bad_gap++;
        last = k;
        pulses++;
      end
    end
    n_cmp++;
    if (first != 19 || pulses != 4 || bad_gap != 0) begin
      n_fail++;
      $display("FAIL slow_period first=%0d pulses=%0d bad_gaps=%0d required 19/4/0", first, pulses, bad_gap);
    end
  endtask

  task automatic test_abort();
    int early_done;
    early_done = 0;
    do_reset(3'b011);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL abort_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (k < 58 && burst_done === 1'b1) early_done++;
      if ((k >= 11 && k <= 15) || k == 16 || k == 58) begin
        n_cmp++;
        if ((k <= 15 && led !== 1'b0) || (k == 16 && led !== 1'b1) ||
            (k == 58 && burst_done !== 1'b1)) begin
          n_fail++;
          $display("FAIL abort_shape k=%0d led=%b done=%b", k, led, burst_done);
        end
      end
      if (k == 10) scale = 3'b111;
    end
    n_cmp++;
    if (early_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%0d pulses required 0", early_done);
    end
  endtask

  task automatic test_err();
    do_reset(3'b010);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL err_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (k <= 20 || k == 22 || k == 26) begin
        n_cmp++;
        if ((k == 22 && led !== 1'b0) || (k != 22 && led !== 1'b1)) begin
          n_fail++;
          $display("FAIL err_shape k=%0d led=%b", k, led);
        end
      end
      if (k == 20) scale = 3'b111;
    end
  endtask

  task automatic test_reset_mid_on();
    do_reset(3'b101);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL midrst_pre k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (led !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_on_before got=%b required 1", led);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== 1'b0 || burst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async led=%b done=%b required 0/0", led, burst_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL midrst_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (k == 1 || k == 5 || k == 9 || k == 35) begin
        n_cmp++;
        if ((k == 5 && led !== 1'b0) || (k != 5 && k != 35 && led !== 1'b1) ||
            (k == 35 && burst_done !== 1'b1)) begin
          n_fail++;
          $display("FAIL midrst_shape k=%0d led=%b done=%b", k, led, burst_done);
        end
      end
    end
  endtask

  task automatic test_change_at_gap();
    int stray_done;
    stray_done = 0;
    do_reset(3'b000);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL gapchg_model k=%0d led=%b/%b done=%b/%b", k, led, exp_led, burst_done, exp_done);
      end
      if (k <= 30 && burst_done === 1'b1) stray_done++;
      if (k == 12 || k == 14) begin
        n_cmp++;
        if ((k == 12 && led !== 1'b0) || (k == 14 && led !== 1'b1)) begin
          n_fail++;
          $display("FAIL gapchg_shape k=%0d led=%b", k, led);
        end
      end
      if (k == 8) scale = 3'b011;
    end
    n_cmp++;
    if (stray_done != 0) begin
      n_fail++;
      $display("FAIL gapchg_no_done got=%0d pulses required 0", stray_done);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 1;
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led !== exp_led || burst_done !== exp_done) begin
        n_fail++;
        $display("FAIL random_model k=%0d scale=%b led=%b/%b done=%b/%b", k, scale, led, exp_led, burst_done, exp_done);
      end
      hold--;
      if (hold == 0) begin
        scale = 3'($urandom_range(0, 7));
        hold = int'($urandom_range(1, 60));
      end
    end
  endtask

  initial begin
    test_reset();
    test_med_101();
    test_slow_period();
    test_abort();
    test_err();
    test_reset_mid_on();
    test_change_at_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
